// File: rtl/hazard_tracker.sv
// Decode-stage hazard unit for the 5-stage MIPS pipeline: stall and forwarding selects from Tuse/Tnew.
// Optional HAZARD_STATS_EN adds free-running stall_cnt / fwd_cnt event counters.
module hazard_tracker #(
  parameter int          REG_AW    = 5,
  parameter logic [1:0]  TUSE_NONE = 2'b11
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [REG_AW-1:0] D_rs,
  input  logic [REG_AW-1:0] D_rt,
  input  logic [1:0]        T_use_rs,
  input  logic [1:0]        T_use_rt,
  input  logic [REG_AW-1:0] D_wa,
  input  logic [1:0]        D_tnew,
  output logic              stall,
  output logic [1:0]        fwd_D_rs,
  output logic [1:0]        fwd_D_rt,
  output logic [1:0]        fwd_E_rs,
  output logic [1:0]        fwd_E_rt
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       fwd_cnt
`endif
);

  logic [REG_AW-1:0] e_wa_q, e_rs_q, e_rt_q, m_wa_q, m_rs_q, m_rt_q, w_wa_q;
  logic [REG_AW-1:0] e_wa_d, e_rs_d, e_rt_d, m_wa_d, m_rs_d, m_rt_d, w_wa_d;
  logic [1:0]        e_tnew_q, m_tnew_q, w_tnew_q;
  logic [1:0]        e_tnew_d, m_tnew_d, w_tnew_d;

  function automatic logic match(input logic [REG_AW-1:0] wa, input logic [REG_AW-1:0] r);
    return (r != '0) && (wa == r);
  endfunction

  // Nearest matching producer wins; a match that is not ready yet blocks older stages.
  function automatic logic [1:0] sel_d(input logic [REG_AW-1:0] r,
                                       input logic [REG_AW-1:0] ewa, input logic [1:0] etn,
                                       input logic [REG_AW-1:0] mwa, input logic [1:0] mtn,
                                       input logic [REG_AW-1:0] wwa, input logic [1:0] wtn);
    if (match(ewa, r))      return (etn == 2'd0) ? 2'b01 : 2'b00;
    else if (match(mwa, r)) return (mtn == 2'd0) ? 2'b10 : 2'b00;
    else if (match(wwa, r)) return (wtn == 2'd0) ? 2'b11 : 2'b00;
    else                    return 2'b00;
  endfunction

  function automatic logic [1:0] sel_e(input logic [REG_AW-1:0] r,
                                       input logic [REG_AW-1:0] mwa, input logic [1:0] mtn,
                                       input logic [REG_AW-1:0] wwa, input logic [1:0] wtn);
    if (match(mwa, r))      return (mtn == 2'd0) ? 2'b10 : 2'b00;
    else if (match(wwa, r)) return (wtn == 2'd0) ? 2'b11 : 2'b00;
    else                    return 2'b00;
  endfunction

  function automatic logic src_stall(input logic [REG_AW-1:0] r, input logic [1:0] tuse,
                                     input logic [REG_AW-1:0] ewa, input logic [1:0] etn,
                                     input logic [REG_AW-1:0] mwa, input logic [1:0] mtn);
    if (tuse == TUSE_NONE) return 1'b0;
    return (match(ewa, r) && (tuse < etn)) || (match(mwa, r) && (tuse < mtn));
  endfunction

  always_comb begin
    stall    = src_stall(D_rs, T_use_rs, e_wa_q, e_tnew_q, m_wa_q, m_tnew_q) ||
               src_stall(D_rt, T_use_rt, e_wa_q, e_tnew_q, m_wa_q, m_tnew_q);
    fwd_D_rs = sel_d(D_rs, e_wa_q, e_tnew_q, m_wa_q, m_tnew_q, w_wa_q, w_tnew_q);
    fwd_D_rt = sel_d(D_rt, e_wa_q, e_tnew_q, m_wa_q, m_tnew_q, w_wa_q, w_tnew_q);
    fwd_E_rs = sel_e(e_rs_q, m_wa_q, m_tnew_q, w_wa_q, w_tnew_q);
    fwd_E_rt = sel_e(e_rt_q, m_wa_q, m_tnew_q, w_wa_q, w_tnew_q);
  end

  always_comb begin
    w_wa_d   = m_wa_q;
    w_tnew_d = 2'd0;
    m_wa_d   = e_wa_q;
    m_rs_d   = e_rs_q;
    m_rt_d   = e_rt_q;
    m_tnew_d = (e_tnew_q == 2'd0) ? 2'd0 : e_tnew_q - 2'd1;
    e_wa_d   = '0;
    e_rs_d   = '0;
    e_rt_d   = '0;
    e_tnew_d = 2'd0;
    // A stalled D instruction stays put and E receives a bubble.
    if (!stall) begin
      e_wa_d   = D_wa;
      e_rs_d   = D_rs;
      e_rt_d   = D_rt;
      e_tnew_d = D_tnew;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      e_wa_q   <= '0;
      e_rs_q   <= '0;
      e_rt_q   <= '0;
      e_tnew_q <= 2'd0;
      m_wa_q   <= '0;
      m_rs_q   <= '0;
      m_rt_q   <= '0;
      m_tnew_q <= 2'd0;
      w_wa_q   <= '0;
      w_tnew_q <= 2'd0;
    end else begin
      e_wa_q   <= e_wa_d;
      e_rs_q   <= e_rs_d;
      e_rt_q   <= e_rt_d;
      e_tnew_q <= e_tnew_d;
      m_wa_q   <= m_wa_d;
      m_rs_q   <= m_rs_d;
      m_rt_q   <= m_rt_d;
      m_tnew_q <= m_tnew_d;
      w_wa_q   <= w_wa_d;
      w_tnew_q <= w_tnew_d;
    end
  end

`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cnt_q, stall_cnt_d, fwd_cnt_q, fwd_cnt_d;
  logic        any_fwd;

  always_comb begin
    any_fwd     = (fwd_D_rs != 2'b00) || (fwd_D_rt != 2'b00) ||
                  (fwd_E_rs != 2'b00) || (fwd_E_rt != 2'b00);
    stall_cnt_d = stall_cnt_q + (stall ? 32'd1 : 32'd0);
    fwd_cnt_d   = fwd_cnt_q + (any_fwd ? 32'd1 : 32'd0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt_q <= '0;
      fwd_cnt_q   <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      fwd_cnt_q   <= fwd_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign fwd_cnt   = fwd_cnt_q;
`endif

  // Lint sink: M-stage source fields are tracked for completeness but not compared here.
  logic unused_m_src;
  assign unused_m_src = ^{m_rs_q, m_rt_q};

endmodule
